// File: rtl/mem_if_pkg.sv
// Shared encodings and defaults for the MAR/MDR memory interface.
// Used by the data-memory responder and its array.
package mem_if_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  // Wait-counter load value; zero wait states bypass WAIT entirely.
  function automatic logic [3:0] cnt_init(input int unsigned wait_cycles);
    return (wait_cycles == 0) ? 4'd0 : 4'(wait_cycles - 1);
  endfunction

endpackage

// File: rtl/mem_array_sp.sv
// Single-port synchronous DEPTH x DATA_W array, registered read, no reset.
module mem_array_sp #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [DEPTH];

  // dout only moves on a read, so it holds the last read value across writes.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[idx] <= din;
      end else begin
        dout <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts single-byte read/write requests, completes them
// after WAIT_CYCLES wait states with a one-cycle done pulse.
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned   IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]    CNT_INIT  = cnt_init(WAIT_CYCLES);
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              op_q;
  logic              err_q, err_d;
  logic              rd_valid_q;

  logic              accept;
  logic              acc_op;
  logic              enter_resp;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_op;
  logic              in_range;
  logic              mem_en;
  logic [DATA_W-1:0] mem_dout;

  always_comb begin
    accept     = (state_q == ST_IDLE) && (rd_req ^ wr_req);
    acc_op     = wr_req ? OP_WR : OP_RD;
    err_d      = (state_q == ST_IDLE) && rd_req && wr_req;
    // With zero wait states the array is accessed on the accepting edge itself,
    // so the live inputs feed it instead of the latched copies.
    enter_resp = ((state_q == ST_WAIT) && (cnt_q == 4'd0)) ||
                 (accept && (WAIT_CYCLES == 0));
    mem_addr   = (state_q == ST_IDLE) ? addr   : addr_q;
    mem_wdata  = (state_q == ST_IDLE) ? wdata  : wdata_q;
    mem_op     = (state_q == ST_IDLE) ? acc_op : op_q;
    in_range   = {1'b0, mem_addr} < DEPTH_LIM;
    mem_en     = enter_resp && in_range;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_q       <= OP_RD;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        op_q    <= acc_op;
      end
      // Out-of-range reads leave the array output alone and force rdata to zero.
      if (enter_resp && (mem_op == OP_RD)) begin
        rd_valid_q <= in_range;
      end
    end
  end

  mem_array_sp #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk  (clk),
    .en   (mem_en),
    .we   (mem_op == OP_WR),
    .idx  (mem_addr[IDX_W-1:0]),
    .din  (mem_wdata),
    .dout (mem_dout)
  );

  assign rdata = rd_valid_q ? mem_dout : '0;
  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_RESP);
  assign err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three builds (2 waits, 0 waits, 3 waits with DEPTH=128)
// checked against a plain array model of the memory.
module tb_data_mem_responder;

  localparam int unsigned WC0 = 2;
  localparam int unsigned WC1 = 0;
  localparam int unsigned WC2 = 3;
  localparam int unsigned DP0 = 256;
  localparam int unsigned DP1 = 256;
  localparam int unsigned DP2 = 128;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rd_req [3];
  logic       wr_req [3];
  logic [7:0] addr   [3];
  logic [7:0] wdata  [3];
  logic [7:0] rdata  [3];
  logic       busy   [3];
  logic       done   [3];
  logic       err    [3];

  int         wc_of  [3];
  int         dp_of  [3];
  logic [7:0] mdl    [3][256];
  logic [7:0] last_rd[3];

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit         is_wr;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(DP0), .WAIT_CYCLES(WC0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req[0]), .wr_req(wr_req[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .busy(busy[0]), .done(done[0]), .err(err[0])
  );
  data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(DP1), .WAIT_CYCLES(WC1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req[1]), .wr_req(wr_req[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .busy(busy[1]), .done(done[1]), .err(err[1])
  );
  data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(DP2), .WAIT_CYCLES(WC2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req[2]), .wr_req(wr_req[2]), .addr(addr[2]),
    .wdata(wdata[2]), .rdata(rdata[2]), .busy(busy[2]), .done(done[2]), .err(err[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One request on instance i; checks timing and returns rdata seen during done.
  task automatic run_access(input int i, input bit is_wr, input logic [7:0] a,
                            input logic [7:0] d, output logic [7:0] got);
    int lat;
    int bn;
    bit es;
    @(negedge clk);
    rd_req[i] = !is_wr;
    wr_req[i] = is_wr;
    addr[i]   = a;
    wdata[i]  = d;
    @(posedge clk);
    @(negedge clk);
    rd_req[i] = 1'b0;
    wr_req[i] = 1'b0;
    addr[i]   = 8'($urandom);
    wdata[i]  = 8'($urandom);
    lat = 0;
    bn  = 0;
    es  = 1'b0;
    got = 'x;
    for (int k = 1; k <= 40; k++) begin
      if (busy[i]) bn++;
      if (err[i]) es = 1'b1;
      if (done[i]) begin
        lat = k;
        got = rdata[i];
        break;
      end
      @(negedge clk);
    end
    check("latency", lat, wc_of[i] + 1);
    check("busy_cycles", bn, wc_of[i] + 1);
    check("err_low", {31'd0, es}, 0);
    @(negedge clk);
    check("busy_drop", {31'd0, busy[i]}, 0);
    check("done_one_cycle", {31'd0, done[i]}, 0);
  endtask

  task automatic do_op(input int i, input bit is_wr, input logic [7:0] a, input logic [7:0] d);
    logic [7:0] exp;
    logic [7:0] got;
    if (is_wr) exp = last_rd[i];
    else exp = (int'(a) < dp_of[i]) ? mdl[i][a] : 8'h00;
    run_access(i, is_wr, a, d, got);
    check(is_wr ? "rdata_held_on_write" : "read_data", {24'd0, got}, {24'd0, exp});
    if (is_wr && int'(a) < dp_of[i]) mdl[i][a] = d;
    if (!is_wr) last_rd[i] = exp;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] got;
    wc_of = '{WC0, WC1, WC2};
    dp_of = '{DP0, DP1, DP2};
    vecs[0] = '{1'b1, 8'h00, 8'h11, 8'hA5};
    vecs[1] = '{1'b1, 8'hFF, 8'h22, 8'hA5};
    vecs[2] = '{1'b0, 8'h00, 8'h00, 8'h11};
    vecs[3] = '{1'b0, 8'hFF, 8'h00, 8'h22};
    vecs[4] = '{1'b1, 8'h00, 8'h33, 8'h22};
    vecs[5] = '{1'b0, 8'h00, 8'h00, 8'h33};
    for (int i = 0; i < 3; i++) begin
      rd_req[i] = 1'b0; wr_req[i] = 1'b0; addr[i] = 8'h00; wdata[i] = 8'h00;
      last_rd[i] = 8'h00;
    end

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_busy", {31'd0, busy[i]}, 0);
      check("reset_done", {31'd0, done[i]}, 0);
      check("reset_err", {31'd0, err[i]}, 0);
      check("reset_rdata", {24'd0, rdata[i]}, 0);
    end
    rst_n = 1'b1;

    for (int a = 0; a < 256; a++) do_op(0, 1'b1, 8'(a), 8'($urandom));
    for (int a = 0; a < 128; a++) do_op(2, 1'b1, 8'(a), 8'($urandom));

    // Write then read with two wait states.
    do_op(0, 1'b1, 8'h10, 8'hA5);
    do_op(0, 1'b0, 8'h10, 8'h00);
    check("wr_rd_a5", {24'd0, last_rd[0]}, 32'hA5);

    for (int v = 0; v < 6; v++) begin
      run_access(0, vecs[v].is_wr, vecs[v].a, vecs[v].d, got);
      check("table_rdata", {24'd0, got}, {24'd0, vecs[v].exp});
      if (vecs[v].is_wr) mdl[0][vecs[v].a] = vecs[v].d;
      else last_rd[0] = vecs[v].exp;
    end

    // Zero wait states: held read request gives done pulses two cycles apart.
    do_op(1, 1'b1, 8'h10, 8'h3C);
    do_op(1, 1'b1, 8'h11, 8'h7E);
    @(negedge clk);
    rd_req[1] = 1'b1; addr[1] = 8'h10;
    @(negedge clk);
    check("b2b_done1", {31'd0, done[1]}, 1);
    check("b2b_rdata1", {24'd0, rdata[1]}, 32'h3C);
    addr[1] = 8'h11;
    @(negedge clk);
    check("b2b_gap_done", {31'd0, done[1]}, 0);
    check("b2b_gap_busy", {31'd0, busy[1]}, 0);
    @(negedge clk);
    check("b2b_done2", {31'd0, done[1]}, 1);
    check("b2b_rdata2", {24'd0, rdata[1]}, 32'h7E);
    rd_req[1] = 1'b0;
    last_rd[1] = 8'h7E;
    @(negedge clk);
    check("b2b_idle", {31'd0, busy[1]}, 0);

    // Both requests high for two cycles: err each cycle, nothing written.
    @(negedge clk);
    rd_req[0] = 1'b1; wr_req[0] = 1'b1; addr[0] = 8'h10; wdata[0] = 8'h00;
    @(negedge clk);
    check("both_err1", {31'd0, err[0]}, 1);
    check("both_done1", {31'd0, done[0]}, 0);
    check("both_busy1", {31'd0, busy[0]}, 0);
    @(negedge clk);
    check("both_err2", {31'd0, err[0]}, 1);
    check("both_done2", {31'd0, done[0]}, 0);
    rd_req[0] = 1'b0; wr_req[0] = 1'b0;
    @(negedge clk);
    check("both_err_clear", {31'd0, err[0]}, 0);
    do_op(0, 1'b0, 8'h10, 8'h00);

    // Request glitch while busy must not disturb the latched read.
    do_op(0, 1'b1, 8'h20, 8'h11);
    do_op(0, 1'b1, 8'h21, 8'h99);
    @(negedge clk);
    rd_req[0] = 1'b1; addr[0] = 8'h20;
    @(negedge clk);
    check("glitch_busy", {31'd0, busy[0]}, 1);
    rd_req[0] = 1'b0; addr[0] = 8'h21; wr_req[0] = 1'b1; wdata[0] = 8'hEE;
    @(negedge clk);
    wr_req[0] = 1'b0;
    @(negedge clk);
    check("glitch_done", {31'd0, done[0]}, 1);
    check("glitch_rdata", {24'd0, rdata[0]}, 32'h11);
    last_rd[0] = 8'h11;
    @(negedge clk);
    do_op(0, 1'b0, 8'h21, 8'h00);

    // DEPTH=128: out-of-range write dropped, read returns zero, no aliasing.
    do_op(2, 1'b1, 8'h10, 8'h5A);
    do_op(2, 1'b1, 8'h90, 8'h55);
    do_op(2, 1'b0, 8'h90, 8'h00);
    check("oor_read_zero", {24'd0, last_rd[2]}, 0);
    do_op(2, 1'b0, 8'h10, 8'h00);

    // Randomized traffic against the model.
    repeat (150) begin
      do_op(0, 1'($urandom), 8'($urandom), 8'($urandom));
      do_op(2, 1'($urandom), 8'($urandom), 8'($urandom));
    end

    // Reset during a write: outputs clear at once, the write is never committed.
    do_op(0, 1'b1, 8'h30, 8'h00);
    do_op(0, 1'b1, 8'h31, 8'h6B);
    do_op(0, 1'b0, 8'h31, 8'h00);
    @(negedge clk);
    wr_req[0] = 1'b1; addr[0] = 8'h30; wdata[0] = 8'hFF;
    @(negedge clk);
    wr_req[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'd0, busy[0]}, 0);
    check("rst_mid_done", {31'd0, done[0]}, 0);
    check("rst_mid_err", {31'd0, err[0]}, 0);
    check("rst_mid_rdata", {24'd0, rdata[0]}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) last_rd[i] = 8'h00;
    do_op(0, 1'b0, 8'h30, 8'h00);
    check("rst_write_dropped", {24'd0, last_rd[0]}, 0);
    do_op(1, 1'b0, 8'h11, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
